userio_db15_scan: RTL

Serial scanner for the DB15 arcade-joystick adapter on the USER port. It drives the adapter's shift-register chain through JOY_LOAD/JOY_CLK and shifts in 24 active-low button bits on JOY_DATA, 12 per player. Each frame is filtered by a two-frame agreement check, then published as two 16-bit active-high joystick words. It sits between the USER_IN/USER_OUT pin muxing and the joystick-select logic in the core top level, which feeds hps_io joy_raw and the game's control inputs.

---
 rtl/userio_db15_scan.sv | 132 +++++++++++++
 1 files changed

// File: rtl/userio_db15_scan.sv
// Serial scanner for the DB15 arcade-joystick adapter: clocks 24 active-low bits out of
// the adapter's shift chain each frame and publishes them after a two-frame agreement check.
module userio_db15_scan #(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned GAP_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        JOY_DATA,
    output logic        JOY_CLK,
    output logic        JOY_LOAD,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic        frame_strobe
);
    localparam int unsigned SLOT  = 2 * CLK_DIV;
    localparam int unsigned PH_W  = $clog2(SLOT);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int unsigned NBITS = 24;
    localparam int unsigned IDX_W = 5;

    typedef enum logic [1:0] {
        S_LOAD,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           state_q,    state_d;
    logic [PH_W-1:0]  phase_q,    phase_d;
    logic [IDX_W-1:0] idx_q,      idx_d;
    logic [GAP_W-1:0] gap_q,      gap_d;
    logic [NBITS-1:0] shift_q,    shift_d;
    logic [NBITS-1:0] prev_q,     prev_d;
    logic [11:0]      joy1_q,     joy1_d;
    logic [11:0]      joy2_q,     joy2_d;
    logic             joy_clk_q,  joy_clk_d;
    logic             joy_load_q, joy_load_d;
    logic             strobe_q,   strobe_d;
    logic             slot_end;

    // Pin outputs are registered from the current state, so the pins trail state/phase by one cycle.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        shift_d    = shift_q;
        prev_d     = prev_q;
        joy1_d     = joy1_q;
        joy2_d     = joy2_q;
        joy_clk_d  = 1'b1;
        joy_load_d = 1'b1;
        strobe_d   = 1'b0;
        slot_end   = (phase_q == PH_W'(SLOT - 1));

        case (state_q)
            S_LOAD: begin
                joy_load_d = 1'b0;
                phase_d    = slot_end ? '0 : phase_q + PH_W'(1);
                if (slot_end) begin
                    state_d = S_SHIFT;
                    idx_d   = '0;
                end
            end
            S_SHIFT: begin
                joy_clk_d = (phase_q >= PH_W'(CLK_DIV));
                phase_d   = slot_end ? '0 : phase_q + PH_W'(1);
                // State phase CLK_DIV coincides with the last low JOY_CLK cycle on the pin.
                if (phase_q == PH_W'(CLK_DIV)) begin
                    shift_d[idx_q] = ~JOY_DATA;
                end
                if (slot_end) begin
                    if (idx_q == IDX_W'(NBITS - 1)) begin
                        state_d  = S_GAP;
                        gap_d    = '0;
                        strobe_d = 1'b1;
                        prev_d   = shift_q;
                        if (shift_q == prev_q) begin
                            joy1_d = shift_q[11:0];
                            joy2_d = shift_q[23:12];
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = S_LOAD;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_LOAD;
            phase_q    <= '0;
            idx_q      <= '0;
            gap_q      <= '0;
            shift_q    <= '0;
            prev_q     <= '0;
            joy1_q     <= '0;
            joy2_q     <= '0;
            joy_clk_q  <= 1'b1;
            joy_load_q <= 1'b1;
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            shift_q    <= shift_d;
            prev_q     <= prev_d;
            joy1_q     <= joy1_d;
            joy2_q     <= joy2_d;
            joy_clk_q  <= joy_clk_d;
            joy_load_q <= joy_load_d;
            strobe_q   <= strobe_d;
        end
    end

    assign JOY_CLK      = joy_clk_q;
    assign JOY_LOAD     = joy_load_q;
    assign frame_strobe = strobe_q;
    assign joystick1    = {4'b0000, joy1_q};
    assign joystick2    = {4'b0000, joy2_q};
endmodule
